// File: rtl/tagged_flow_pkg.sv
// tagged_flow_pkg: shared types and helpers for the tagged flow multiplexer
package tagged_flow_pkg;
   typedef enum logic {IDLE, ARMED} ch_state_t;
   function automatic int tag_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   localparam int TOK_TAG_W = 2;
   localparam int TOK_DATA_W = 8;
   // Output word layout for the default four-flow, byte-payload geometry
   typedef struct packed {
      logic [TOK_TAG_W-1:0]  tag;
      logic [TOK_DATA_W-1:0] data;
   } token_t;
endpackage

// File: rtl/flow_fifo.sv
// flow_fifo: per-flow ingress FIFO, drops pushes while full and flags them
module flow_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic              ovf
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   // Wrap bit distinguishes full from empty when the indices match
   assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign empty = wp == rp;
   assign head = mem[rp[AW-1:0]];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wp <= '0;
         rp <= '0;
         ovf <= 1'b0;
      end else begin
         ovf <= push && full;
         if (push && !full) wp <= wp + 1'b1;
         if (pop && !empty) rp <= rp + 1'b1;
      end
   always_ff @(posedge clk)
      if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/tagged_flow_mux.sv
// tagged_flow_mux: round-robin merge of budgeted per-flow FIFOs into one tagged stream
module tagged_flow_mux
   import tagged_flow_pkg::*;
#(
   parameter int FLUX = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH = 16,
   parameter int LEN_W = 16,
   localparam int TAG_W = tag_w(FLUX)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_write,
   input  logic [TAG_W-1:0]        cfg_ch,
   input  logic [LEN_W-1:0]        cfg_len,
   output logic                    cfg_err,
   input  logic [FLUX-1:0]         in_write,
   input  logic [FLUX*DATA_W-1:0]  in_din,
   output logic [FLUX-1:0]         in_full,
   output logic [FLUX-1:0]         in_ovf,
   output logic                    out_write,
   output logic [TAG_W+DATA_W-1:0] out_din,
   input  logic [FLUX-1:0]         out_full,
   output logic [FLUX-1:0]         ch_busy,
   output logic [FLUX-1:0]         ch_done
);
   ch_state_t st [FLUX];
   logic [LEN_W-1:0] rem [FLUX];
   logic [DATA_W-1:0] head [FLUX];
   logic [FLUX-1:0] empty, elig, pop;
   logic [TAG_W-1:0] last_grant, gnt;
   logic gnt_v, cfg_ok;
   for (genvar i = 0; i < FLUX; i++) begin : g_fifo
      flow_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
         .clk(clk),
         .rst(rst),
         .push(in_write[i]),
         .din(in_din[i*DATA_W +: DATA_W]),
         .pop(pop[i]),
         .head(head[i]),
         .full(in_full[i]),
         .empty(empty[i]),
         .ovf(in_ovf[i])
      );
      assign ch_busy[i] = st[i] == ARMED;
      assign elig[i] = ch_busy[i] && !empty[i] && !out_full[i];
   end
   // Search starts just after the last winner so every armed flow gets its turn
   always_comb begin
      gnt_v = 1'b0;
      gnt = '0;
      for (int i = 1; i <= FLUX; i++)
         if (!gnt_v && elig[(int'(last_grant) + i) % FLUX]) begin
            gnt_v = 1'b1;
            gnt = TAG_W'((int'(last_grant) + i) % FLUX);
         end
   end
   assign pop = gnt_v ? FLUX'(1) << gnt : '0;
   assign cfg_ok = cfg_write && cfg_len != '0 && int'(cfg_ch) < FLUX && !ch_busy[cfg_ch];
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         out_write <= 1'b0;
         out_din <= '0;
         cfg_err <= 1'b0;
         ch_done <= '0;
         last_grant <= TAG_W'(FLUX - 1);
         for (int c = 0; c < FLUX; c++) begin
            st[c] <= IDLE;
            rem[c] <= '0;
         end
      end else begin
         out_write <= gnt_v;
         cfg_err <= cfg_write && !cfg_ok;
         if (gnt_v) begin
            out_din <= {gnt, head[gnt]};
            last_grant <= gnt;
         end
         for (int c = 0; c < FLUX; c++) begin
            ch_done[c] <= pop[c] && rem[c] == LEN_W'(1);
            if (pop[c]) rem[c] <= rem[c] - 1'b1;
            if (pop[c] && rem[c] == LEN_W'(1)) st[c] <= IDLE;
            if (cfg_ok && cfg_ch == TAG_W'(c)) begin
               st[c] <= ARMED;
               rem[c] <= cfg_len;
            end
         end
      end
endmodule

// File: tb/tb_tagged_flow_mux.sv
// tb_tagged_flow_mux: directed vector table plus multi-cycle sequences for tagged_flow_mux
module tb_tagged_flow_mux;
   import tagged_flow_pkg::*;
   logic clk = 1'b0;
   logic rst;
   logic cfg_write;
   logic [1:0] cfg_ch;
   logic [15:0] cfg_len;
   logic cfg_err;
   logic [3:0] in_write, in_full, in_ovf, out_full, ch_busy, ch_done;
   logic [31:0] in_din;
   logic out_write;
   logic [9:0] out_din;
   int n_tests = 0, n_fail = 0, cyc = 0, done_cnt = 0, ovf_cnt = 0;
   logic [9:0] got [$];
   int stamp [$];
   typedef struct {
      logic        cw;
      logic [1:0]  cc;
      logic [15:0] cl;
      logic [3:0]  iw;
      logic [31:0] id;
      logic [9:0]  ed;
      logic        ew;
      logic [3:0]  edone;
      logic [3:0]  ebusy;
      logic        eerr;
   } vec_t;
   vec_t tbl [13];

   tagged_flow_mux #(.FLUX(4), .DATA_W(8), .DEPTH(16), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .cfg_write(cfg_write), .cfg_ch(cfg_ch), .cfg_len(cfg_len),
      .cfg_err(cfg_err), .in_write(in_write), .in_din(in_din), .in_full(in_full),
      .in_ovf(in_ovf), .out_write(out_write), .out_din(out_din), .out_full(out_full),
      .ch_busy(ch_busy), .ch_done(ch_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rst) begin
         if (out_write) begin
            got.push_back(out_din);
            stamp.push_back(cyc);
         end
         done_cnt += $countones(ch_done);
         ovf_cnt += $countones(in_ovf);
      end

   function automatic token_t tok(input int c, input int d);
      tok.tag = 2'(c);
      tok.data = 8'(d);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      stamp.delete();
      done_cnt = 0;
      ovf_cnt = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cfg_write = 1'b0;
      in_write = '0;
      in_din = '0;
      out_full = '0;
      tick();
      rst = 1'b1;
      tick();
      clear_mon();
   endtask

   task automatic cfg(input int ch, input int len);
      cfg_write = 1'b1;
      cfg_ch = 2'(ch);
      cfg_len = 16'(len);
      tick();
      cfg_write = 1'b0;
   endtask

   initial begin
      int n0, n1, early, first1, rel;
      rst = 1'b0;
      cfg_write = 1'b0;
      cfg_ch = '0;
      cfg_len = '0;
      in_write = '0;
      in_din = '0;
      out_full = '0;
      tick();
      chk("rst_out_write", out_write, 0);
      chk("rst_out_din", out_din, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_in_ovf", in_ovf, 0);
      chk("rst_ch_done", ch_done, 0);
      chk("rst_ch_busy", ch_busy, 0);
      chk("rst_in_full", in_full, 0);
      rst = 1'b1;
      tick();
      clear_mon();

      // Interleave ch0 (A0..A2) and ch2 (C0,C1), then the config rejection cases
      tbl[0]  = '{1'b1, 2'd0, 16'd3, 4'h0, 32'h0,        10'h000, 1'b0, 4'h0, 4'h1, 1'b0};
      tbl[1]  = '{1'b1, 2'd2, 16'd2, 4'h0, 32'h0,        10'h000, 1'b0, 4'h0, 4'h5, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 16'd0, 4'h5, 32'h00C000A0, 10'h000, 1'b0, 4'h0, 4'h5, 1'b0};
      tbl[3]  = '{1'b0, 2'd0, 16'd0, 4'h5, 32'h00C100A1, 10'h0A0, 1'b1, 4'h0, 4'h5, 1'b0};
      tbl[4]  = '{1'b0, 2'd0, 16'd0, 4'h1, 32'h000000A2, 10'h2C0, 1'b1, 4'h0, 4'h5, 1'b0};
      tbl[5]  = '{1'b0, 2'd0, 16'd0, 4'h0, 32'h0,        10'h0A1, 1'b1, 4'h0, 4'h5, 1'b0};
      tbl[6]  = '{1'b0, 2'd0, 16'd0, 4'h0, 32'h0,        10'h2C1, 1'b1, 4'h4, 4'h1, 1'b0};
      tbl[7]  = '{1'b0, 2'd0, 16'd0, 4'h0, 32'h0,        10'h0A2, 1'b1, 4'h1, 4'h0, 1'b0};
      tbl[8]  = '{1'b0, 2'd0, 16'd0, 4'h0, 32'h0,        10'h0A2, 1'b0, 4'h0, 4'h0, 1'b0};
      tbl[9]  = '{1'b1, 2'd1, 16'd5, 4'h0, 32'h0,        10'h0A2, 1'b0, 4'h0, 4'h2, 1'b0};
      tbl[10] = '{1'b1, 2'd1, 16'd7, 4'h0, 32'h0,        10'h0A2, 1'b0, 4'h0, 4'h2, 1'b1};
      tbl[11] = '{1'b1, 2'd2, 16'd0, 4'h0, 32'h0,        10'h0A2, 1'b0, 4'h0, 4'h2, 1'b1};
      tbl[12] = '{1'b0, 2'd0, 16'd0, 4'h0, 32'h0,        10'h0A2, 1'b0, 4'h0, 4'h2, 1'b0};
      for (int i = 0; i < 13; i++) begin
         cfg_write = tbl[i].cw;
         cfg_ch = tbl[i].cc;
         cfg_len = tbl[i].cl;
         in_write = tbl[i].iw;
         in_din = tbl[i].id;
         tick();
         chk($sformatf("vec%0d_out_write", i), out_write, tbl[i].ew);
         chk($sformatf("vec%0d_out_din", i), out_din, tbl[i].ed);
         chk($sformatf("vec%0d_ch_done", i), ch_done, tbl[i].edone);
         chk($sformatf("vec%0d_ch_busy", i), ch_busy, tbl[i].ebusy);
         chk($sformatf("vec%0d_cfg_err", i), cfg_err, tbl[i].eerr);
      end
      cfg_write = 1'b0;
      in_write = '0;

      // ch1 kept its budget of 5 despite the rejected rewrite
      clear_mon();
      for (int i = 0; i < 7; i++) begin
         in_write = 4'b0010;
         in_din = '0;
         in_din[15:8] = 8'(16 + i);
         tick();
      end
      in_write = '0;
      repeat (8) tick();
      chk("rem_count", got.size(), 5);
      for (int k = 0; k < 5; k++)
         chk($sformatf("rem_tok%0d", k), k < got.size() ? got[k] : 10'h3FF, tok(1, 16 + k));
      chk("rem_done", done_cnt, 1);
      chk("rem_busy", ch_busy, 0);

      // Four full FIFOs, four budgets of 4: strict 0,1,2,3 rotation, back to back
      do_reset();
      for (int i = 0; i < 16; i++) begin
         in_write = 4'hF;
         for (int c = 0; c < 4; c++) in_din[c*8 +: 8] = 8'(c * 16 + i);
         tick();
      end
      in_write = '0;
      chk("rr_full_loaded", in_full, 4'hF);
      out_full = 4'hF;
      for (int c = 0; c < 4; c++) cfg(c, 4);
      out_full = '0;
      repeat (20) tick();
      chk("rr_count", got.size(), 16);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("rr_tok%0d", i), i < got.size() ? got[i] : 10'h3FF, tok(i % 4, (i % 4) * 16 + i / 4));
         if (i > 0)
            chk($sformatf("rr_gap%0d", i), i < stamp.size() ? stamp[i] - stamp[i-1] : 0, 1);
      end
      chk("rr_done", done_cnt, 4);
      chk("rr_busy", ch_busy, 0);
      chk("rr_full_after", in_full, 0);

      // Backpressure on ch1 for 10 cycles while ch0 keeps flowing
      do_reset();
      out_full = 4'b0010;
      cfg(0, 8);
      cfg(1, 4);
      for (int i = 0; i < 8; i++) begin
         in_write = i < 4 ? 4'b0011 : 4'b0001;
         in_din = '0;
         in_din[7:0] = 8'(32 + i);
         in_din[15:8] = 8'(48 + i);
         tick();
      end
      in_write = '0;
      rel = cyc;
      out_full = '0;
      repeat (15) tick();
      n0 = 0;
      n1 = 0;
      early = 0;
      first1 = -1;
      for (int i = 0; i < got.size(); i++)
         if (got[i][9:8] == 2'd0) begin
            chk($sformatf("bp_ch0_tok%0d", n0), got[i], tok(0, 32 + n0));
            n0++;
         end else begin
            chk($sformatf("bp_ch1_tok%0d", n1), got[i], tok(1, 48 + n1));
            if (stamp[i] <= rel) early++;
            if (first1 < 0) first1 = stamp[i];
            n1++;
         end
      chk("bp_n0", n0, 8);
      chk("bp_n1", n1, 4);
      chk("bp_hold", early, 0);
      chk("bp_resume", first1 > rel && first1 <= rel + 2, 1);

      // Overfill idle ch3: full after 16, one drop pulse, nothing emitted
      do_reset();
      for (int i = 0; i < 17; i++) begin
         in_write = 4'b1000;
         in_din = '0;
         in_din[31:24] = 8'(i);
         tick();
         if (i == 14) chk("ovf_not_full15", in_full, 0);
         if (i == 15) chk("ovf_full16", in_full, 4'b1000);
         if (i == 16) chk("ovf_pulse", in_ovf, 4'b1000);
      end
      in_write = '0;
      tick();
      chk("ovf_pulse_end", in_ovf, 0);
      tick();
      chk("ovf_count", ovf_cnt, 1);
      chk("ovf_no_out", got.size(), 0);
      chk("ovf_busy", ch_busy, 0);

      // Reset mid-stream, then re-arm: only post-reset data may appear
      do_reset();
      cfg(0, 12);
      for (int i = 0; i < 12 && got.size() < 5; i++) begin
         in_write = 4'b0001;
         in_din = 32'(8'h40 + i);
         tick();
      end
      in_write = '0;
      for (int i = 0; i < 50 && got.size() < 5; i++) tick();
      chk("rst_wait_5", got.size() >= 5, 1);
      rst = 1'b0;
      #2;
      chk("mid_out_write", out_write, 0);
      chk("mid_out_din", out_din, 0);
      chk("mid_ch_busy", ch_busy, 0);
      chk("mid_ch_done", ch_done, 0);
      chk("mid_in_full", in_full, 0);
      chk("mid_in_ovf", in_ovf, 0);
      tick();
      rst = 1'b1;
      tick();
      clear_mon();
      cfg(0, 2);
      in_write = 4'b0001;
      in_din = 32'h77;
      tick();
      in_din = 32'h78;
      tick();
      in_write = '0;
      repeat (6) tick();
      chk("post_rst_count", got.size(), 2);
      chk("post_rst_first", got.size() > 0 ? got[0] : 10'h3FF, tok(0, 8'h77));
      chk("post_rst_second", got.size() > 1 ? got[1] : 10'h3FF, tok(0, 8'h78));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
